// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory responder with programmable wait states and a one-cycle response pulse.
// Optional DMEM_MMIO_EN maps the all-ones address to the mmio_out register.
module data_mem_responder #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] mmio_out
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
    state_t state_q;
    logic [3:0] cnt_q;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q, mmio_q;
    logic write_q, req_ready_q, resp_valid_q, err_q;
    logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2] = '{default: '0};
    logic accept, access, acc_write, in_range, is_mmio;
    logic [DATA_WIDTH-1:0] acc_addr, acc_wdata;
    logic [DEPTH_LOG2-1:0] idx;
    // With zero wait states the access edge is the acceptance edge, so the live request is used.
    assign accept    = req_valid && req_ready_q;
    assign access    = (state_q == S_WAIT && cnt_q == 4'd1) || (accept && WAIT_STATES == 0);
    assign acc_addr  = state_q == S_IDLE ? req_addr : addr_q;
    assign acc_wdata = state_q == S_IDLE ? req_wdata : wdata_q;
    assign acc_write = state_q == S_IDLE ? req_write : write_q;
    assign in_range  = acc_addr[DATA_WIDTH-1:DEPTH_LOG2] == '0;
    assign idx       = acc_addr[DEPTH_LOG2-1:0];
`ifdef DMEM_MMIO_EN
    assign is_mmio = acc_addr == '1;
`else
    assign is_mmio = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            mmio_q       <= '0;
        end else begin
            resp_valid_q <= access;
            if (access) begin
                rdata_q <= acc_write ? '0 : is_mmio ? mmio_q : in_range ? mem[idx] : '0;
                err_q   <= !in_range && !is_mmio;
                if (is_mmio && acc_write) mmio_q <= acc_wdata;
            end
            case (state_q)
                S_IDLE: if (accept) begin
                    addr_q      <= req_addr;
                    wdata_q     <= req_wdata;
                    write_q     <= req_write;
                    cnt_q       <= 4'(WAIT_STATES);
                    req_ready_q <= 1'b0;
                    state_q     <= WAIT_STATES == 0 ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= S_RESP;
                end
                S_RESP: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
    // The RAM has no reset; a reset coinciding with the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && access && acc_write && in_range) mem[idx] <= acc_wdata;
    end
    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mmio_out   = mmio_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder (WAIT_STATES=2, DEPTH_LOG2=8).
module tb_data_mem_responder;
    localparam int WS = 2;
    logic clk = 0, rst = 1, req_valid = 0, req_write = 0, req_ready, resp_valid, resp_err;
    logic [15:0] req_addr = 0, req_wdata = 0, resp_rdata, mmio_out;
    data_mem_responder #(.DATA_WIDTH(16), .DEPTH_LOG2(8), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mmio_out(mmio_out));
    always #5 clk = ~clk;
    typedef struct {logic w; logic [15:0] a, d, rd; logic err; int acc;} txn_t;
    txn_t sb[$];
    logic [15:0] mdl [256];
    logic [15:0] mmio_m = 0;
    int n_chk = 0, n_fail = 0, cyc = 0, n_acc = 0, last_acc = 0;
    bit gap_on = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic bit is_mmio(input logic [15:0] a);
`ifdef DMEM_MMIO_EN
        return a == 16'hFFFF;
`else
        return 0;
`endif
    endfunction
    always @(posedge clk) cyc++;
    // Expected results are formed at acceptance; stores update the model when their response appears.
    always @(negedge clk) if (!rst) begin
        txn_t t;
        if (resp_valid) begin
            if (sb.size() == 0) check("spurious_resp", 1, 0);
            else begin
                t = sb.pop_front();
                check("rdata", resp_rdata, t.rd);
                check("err", resp_err, t.err);
                check("latency", cyc - t.acc, WS);
                if (t.w && t.a < 256) mdl[t.a[7:0]] = t.d;
                if (t.w && is_mmio(t.a)) mmio_m = t.d;
                check("mmio", mmio_out, mmio_m);
            end
        end
        if (req_valid && req_ready) begin
            t.w = req_write; t.a = req_addr; t.d = req_wdata; t.acc = cyc + 1;
            t.rd = req_write ? 16'h0 : is_mmio(req_addr) ? mmio_m : req_addr < 256 ? mdl[req_addr[7:0]] : 16'h0;
            t.err = req_addr >= 256 && !is_mmio(req_addr);
            sb.push_back(t);
            if (gap_on) check("accept_gap", cyc + 1 - last_acc, WS + 2);
            last_acc = cyc + 1;
            n_acc++;
        end
    end
    task automatic req(input logic w, input logic [15:0] a, input logic [15:0] d, input bit wait_resp);
        int s, t;
        @(posedge clk); #1;
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
        s = n_acc; t = 0;
        while (n_acc == s && t < 20) begin @(posedge clk); t++; end
        check("accept_timeout", t < 20, 1);
        #1 req_valid = 0;
        if (wait_resp) drain();
    endtask
    task automatic drain();
        int t;
        t = 0;
        while (sb.size() > 0 && t < 20) begin @(posedge clk); t++; end
        check("resp_timeout", sb.size(), 0);
        @(negedge clk);
    endtask
    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1; sb.delete(); mmio_m = 0;
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", resp_err, 0);
        check("rst_mmio", mmio_out, 0);
        @(posedge clk); #1 rst = 0;
    endtask
    initial begin
        int s0;
        for (int i = 0; i < 256; i++) mdl[i] = 0;
        #12;
        check("init_ready", req_ready, 1);
        check("init_valid", resp_valid, 0);
        @(posedge clk); #1 rst = 0;
        req(1, 16'h0005, 16'h1234, 1);
        req(0, 16'h0005, 16'h0000, 1);
        req(1, 16'hFFFF, 16'h00A5, 1);
        req(0, 16'hFFFF, 16'h0000, 1);
        do_reset();
        req(1, 16'h0000, 16'h0042, 1);
        req(1, 16'h0100, 16'h5A5A, 1);
        req(0, 16'h0100, 16'h0000, 1);
        req(0, 16'h0000, 16'h0000, 1);
        req(0, 16'h0005, 16'h0000, 1);
        s0 = n_acc;
        @(posedge clk); #1;
        req_valid = 1; req_write = 0; req_addr = 16'h0005;
        for (int k = 0; k < 4; k++) begin
            int s, t;
            s = n_acc; t = 0;
            while (n_acc == s && t < 20) begin @(posedge clk); t++; end
            check("stream_accept_timeout", t < 20, 1);
            #1 req_write = 1; req_addr = 16'h0005; req_wdata = 16'hDEAD;
            @(negedge clk) check("ready_wait1", req_ready, 0);
            @(posedge clk) #1 req_addr = 16'h0003;
            @(negedge clk) check("ready_wait2", req_ready, 0);
            @(posedge clk) #1 req_write = 0; req_addr = (k % 2) ? 16'h0005 : 16'h0000; req_valid = k < 3;
            @(negedge clk) check("ready_resp", req_ready, 0);
            if (k == 0) gap_on = 1;
        end
        drain();
        gap_on = 0;
        check("stream_count", n_acc - s0, 4);
        req(1, 16'h0007, 16'h0007, 1);
        req(1, 16'h0007, 16'hBEEF, 0);
        @(posedge clk); #1;
        rst = 1; sb.delete(); mmio_m = 0;
        #1 check("abort_valid", resp_valid, 0);
        @(posedge clk); #1 rst = 0;
        repeat (5) @(posedge clk);
        req(0, 16'h0007, 16'h0000, 1);
        req(1, 16'h0010, 16'hC0DE, 1);
        req(0, 16'h0110, 16'h0000, 1);
        req(0, 16'h0010, 16'h0000, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
